// File: rtl/seq_det_pkg.sv
// Shared constants, overlap-mode encoding and the pattern-length legality
// check for the programmable sequence detector.
package seq_det_pkg;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_t;

  localparam int DFLT_MAX_LEN = 16;
  localparam int DFLT_CNT_W   = 8;
  localparam int DFLT_LEN     = 8;
  localparam logic [31:0] DFLT_PATTERN = 32'h0000_0055;

  function automatic logic len_ok(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Masked equality of the low len bits of history against the pattern.
// Purely combinational.
module seq_det_cmp #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic [MAX_LEN-1:0] history,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               eq
);

  logic [MAX_LEN-1:0] mask;

  // NOTE: every output of an always_comb gets a value before any condition, so no latch is inferred.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    eq = ((history ^ pattern) & mask) == '0;
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap control,
// input qualification and a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DFLT_MAX_LEN,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = DFLT_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DFLT_PATTERN),
  parameter int DEF_LEN = DFLT_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               din,
  input  logic               din_valid,
  input  logic               clr_cnt,
  output logic               flag,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  ovl_mode_t          overlap;
  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_inc;
  logic               sample;
  logic               cfg_ok;
  logic               eq;
  logic               match;

  // Match is judged on the history/fill as they will be after this edge.
  assign sample   = din_valid & ~cfg_we;
  assign hist_nxt = {history[MAX_LEN-2:0], din};
  assign fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
  assign cfg_ok   = len_ok(int'(cfg_len), MAX_LEN);

  seq_det_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .history (hist_nxt),
    .pattern (pattern),
    .len     (len),
    .eq      (eq)
  );

  assign match = sample && (fill_inc >= len) && eq;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= DEF_PATTERN;
      len     <= LEN_W'(DEF_LEN);
      overlap <= OVL_ON;
      history <= '0;
      fill    <= '0;
      flag    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      flag    <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (cfg_ok) begin
          pattern <= cfg_pattern;
          len     <= cfg_len;
          overlap <= ovl_mode_t'(cfg_overlap);
          fill    <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (din_valid) begin
        history <= hist_nxt;
        fill    <= (match && overlap == OVL_OFF) ? '0 : fill_inc;
        flag    <= match;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
    end else if (match && match_cnt != '1) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench: a bit-queue reference model predicts flag/cfg_err/match_cnt
// per clock; a monitor compares after every rising edge.
module tb_seq_detector_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [15:0] cfg_pattern;
  logic [4:0]  cfg_len;
  logic        cfg_overlap;
  logic        cfg_err;
  logic        din;
  logic        din_valid;
  logic        clr_cnt;
  logic        flag;
  logic [7:0]  match_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic flag;
    logic err;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the valid bits seen since the last clear, newest last.
  logic [15:0] m_pat;
  int          m_len;
  bit          m_ovl;
  bit          m_bits[$];
  int          m_cnt;

  seq_detector_prog dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .din         (din),
    .din_valid   (din_valid),
    .clr_cnt     (clr_cnt),
    .flag        (flag),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat = 16'h0055;
    m_len = 8;
    m_ovl = 1'b1;
    m_bits.delete();
    m_cnt = 0;
  endtask

  // Drive one clock's inputs and queue the response the next edge must produce.
  task automatic cycle(input logic r, input logic we, input logic [15:0] pat,
                       input logic [4:0] len, input logic ovl, input logic d,
                       input logic v, input logic clr);
    exp_t e;
    bit   m;
    @(negedge clk);
    rst = r; cfg_we = we; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; din = d; din_valid = v; clr_cnt = clr;
    e.err = 1'b0;
    m = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (we) begin
        if (len >= 1 && len <= 16) begin
          m_pat = pat; m_len = int'(len); m_ovl = ovl;
          m_bits.delete();
        end else begin
          e.err = 1'b1;
        end
      end else if (v) begin
        m_bits.push_back(d);
        if (m_bits.size() > 16) void'(m_bits.pop_front());
        if (m_bits.size() >= m_len) begin
          m = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (m_bits[m_bits.size()-1-k] != m_pat[k]) m = 1'b0;
        end
        if (m && !m_ovl) m_bits.delete();
      end
      if (clr) m_cnt = 0;
      else if (m && m_cnt < 255) m_cnt++;
    end
    e.flag = m;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic bit_in(input logic d);
    cycle(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, d, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [15:0] pat, input logic [4:0] len, input logic ovl);
    cycle(1'b0, 1'b1, pat, len, ovl, 1'b1, 1'b1, 1'b0);
  endtask

  // Sends n bits, most significant (earliest) first.
  task automatic stream(input int n, input logic [31:0] bits);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("flag", int'(flag), int'(e.flag));
        check("cfg_err", int'(cfg_err), int'(e.err));
        check("match_cnt", int'(match_cnt), e.cnt);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_cnt", int'(match_cnt), 0);
    check("reset_flag", int'(flag), 0);
    check("reset_err", int'(cfg_err), 0);
    cycle(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Default 01010101, overlapping: matches after bits 8 and 10.
    stream(10, 32'b0101010101);
    idle();
    check("default_cnt", int'(match_cnt), 2);

    // 0101, non-overlapping: matches after bits 4 and 8 only.
    cfg(16'h0005, 5'd4, 1'b0);
    stream(8, 32'b01010101);
    idle();
    check("nonovl_cnt", int'(match_cnt), 4);

    // 110 with a qualification gap before the final bit.
    cfg(16'h0006, 5'd3, 1'b1);
    bit_in(1'b1); bit_in(1'b1);
    idle(); idle(); idle();
    bit_in(1'b0);
    idle();
    check("gap_cnt", int'(match_cnt), 5);

    // Illegal lengths are rejected and the old pattern keeps detecting.
    cfg(16'hFFFF, 5'd0, 1'b0);
    cfg(16'hFFFF, 5'd17, 1'b0);
    stream(3, 32'b110);
    idle();
    check("badcfg_cnt", int'(match_cnt), 6);

    // Reset after 7 of 8 default bits discards the partial match.
    stream(7, 32'b0101010);
    cycle(1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_async_cnt", int'(match_cnt), 0);
    idle();
    bit_in(1'b1);
    idle();
    check("rst_partial_cnt", int'(match_cnt), 0);
    stream(8, 32'b01010101);
    idle();
    check("rst_full_cnt", int'(match_cnt), 1);

    // Saturation, then clear together with a match.
    cfg(16'h0001, 5'd1, 1'b0);
    repeat (260) bit_in(1'b1);
    idle();
    check("sat_cnt", int'(match_cnt), 255);
    cycle(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle();
    check("clr_vs_match", int'(match_cnt), 0);

    // Randomised traffic with occasional reconfiguration, clears and resets.
    repeat (2000) begin
      logic        r, we, clr, v, d, ovl;
      logic [4:0]  len;
      logic [15:0] pat;
      r   = ($urandom_range(0, 399) == 0);
      we  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 4) != 0);
      d   = 1'($urandom);
      ovl = 1'($urandom);
      pat = 16'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(1, 5));
      cycle(r, we, pat, len, ovl, d, v, clr);
    end
    idle();

    @(posedge clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
